// File: rtl/shift_cmd_queue.sv
// Command FIFO feeding an external combinational shifter, with a registered
// result stage and ready/valid handshakes on both sides.
module shift_cmd_queue #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = 3,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [SHAMT_WIDTH-1:0]   in_shamt,
  input  logic                     in_lr,
  input  logic                     in_al,
  output logic [DATA_WIDTH-1:0]    sh_data,
  output logic [SHAMT_WIDTH-1:0]   sh_shamt,
  output logic                     sh_lr,
  output logic                     sh_al,
  input  logic [DATA_WIDTH-1:0]    sh_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               done_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   lr;
    logic                   al;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          in_cmd, head_cmd;
  logic [PW-1:0] head, tail;
  logic          push, pop;

  assign in_cmd   = '{data: in_data, shamt: in_shamt, lr: in_lr, al: in_al};
  // in_ready looks only at occupancy so a full queue never relies on a same-cycle pop
  assign in_ready = (level != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (level != '0) && (!out_valid || out_ready);

  always_comb begin
    head_cmd = '0;
    if (level != '0) head_cmd = mem[head];
  end

  assign sh_data  = head_cmd.data;
  assign sh_shamt = head_cmd.shamt;
  assign sh_lr    = head_cmd.lr;
  assign sh_al    = head_cmd.al;

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[tail] <= in_cmd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done_cnt  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (pop) begin
        out_data  <= sh_result;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) done_cnt <= done_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Scoreboard bench for shift_cmd_queue with a behavioural shifter attached.
module tb_shift_cmd_queue;

  logic       clk, rst_n;
  logic       in_valid, in_ready, in_lr, in_al;
  logic [7:0] in_data, sh_data, sh_result, out_data, done_cnt;
  logic [2:0] in_shamt, sh_shamt, level;
  logic       sh_lr, sh_al, out_valid, out_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb [$];

  shift_cmd_queue #(.DATA_WIDTH(8), .SHAMT_WIDTH(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_lr(in_lr), .in_al(in_al),
    .sh_data(sh_data), .sh_shamt(sh_shamt), .sh_lr(sh_lr), .sh_al(sh_al),
    .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .done_cnt(done_cnt)
  );

  function automatic logic [7:0] shf(input logic [7:0] d, input logic [2:0] s,
                                     input logic lr, input logic al);
    logic signed [7:0] sd;
    sd = d;
    if (!lr)    return d << s;
    else if (al) return 8'(sd >>> s);
    else        return d >> s;
  endfunction

  assign sh_result = shf(sh_data, sh_shamt, sh_lr, sh_al);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s,
                       input logic lr, input logic al);
    in_valid = v; in_data = d; in_shamt = s; in_lr = lr; in_al = al;
  endtask

  // Scoreboard: decide at negedge what the coming edge will accept/consume
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sb_order", out_data, e);
        end
      end
      if (in_valid && in_ready) sb.push_back(shf(in_data, in_shamt, in_lr, in_al));
    end
  end

  initial begin
    int acc, res, stall;
    logic [7:0] first_exp;

    // reset with a push presented that must be ignored
    rst_n = 1'b0; out_ready = 1'b0;
    drive(1'b1, 8'hAA, 3'd1, 1'b0, 1'b0);
    step();
    chk("rst_in_ready", in_ready, 1);
    step();
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_sh", {sh_data, sh_shamt, sh_lr, sh_al}, 0);
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk("post_rst_level", level, 0);

    // single arithmetic right shift, 2-edge latency
    out_ready = 1'b1;
    drive(1'b1, 8'h96, 3'd2, 1'b1, 1'b1);
    step();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("single_lvl1", level, 1);
    chk("single_novalid", out_valid, 0);
    chk("single_sh_data", sh_data, 8'h96);
    step();
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'hE5);
    step();
    chk("single_done", done_cnt, 1);
    chk("single_drained", out_valid, 0);

    // logical left
    drive(1'b1, 8'h96, 3'd3, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk("lsl_data", out_data, 8'hB0);
    step();

    // backpressure fill
    out_ready = 1'b0;
    acc = 0;
    first_exp = 8'h00;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      if (in_ready) begin
        if (acc == 0) first_exp = shf(in_data, in_shamt, in_lr, in_al);
        acc++;
      end
      step();
    end
    chk("fill_accepted", acc, 5);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_level", level, 4);
    chk("fill_valid", out_valid, 1);
    chk("fill_hold", out_data, first_exp);
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // drain: order checked by scoreboard
    out_ready = 1'b1;
    res = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) res++;
      step();
    end
    chk("drain_results", res, 5);
    chk("drain_level", level, 0);
    chk("drain_valid", out_valid, 0);
    chk("drain_sb_empty", sb.size(), 0);

    // streaming 300 from a clean reset
    rst_n = 1'b0; step(); rst_n = 1'b1;
    stall = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      if (!in_ready) stall++;
      if (i >= 2 && !out_valid) stall++;
      step();
    end
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && (out_valid || level != 0); i++) step();
    chk("stream_stalls", stall, 0);
    chk("stream_done_cnt", done_cnt, 44);
    chk("stream_sb_empty", sb.size(), 0);

    // build level=3 with a held result, push+pop at DEPTH-1, then reset
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    chk("mid_level3", level, 3);
    chk("mid_valid", out_valid, 1);
    out_ready = 1'b1;
    drive(1'b1, 8'h5A, 3'd1, 1'b1, 1'b0);
    step();
    chk("pushpop_level", level, 3);
    chk("pushpop_valid", out_valid, 1);
    rst_n = 1'b0;
    drive(1'b1, 8'h33, 3'd1, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_done", done_cnt, 0);
    chk("mid_rst_sh", {sh_data, sh_shamt, sh_lr, sh_al}, 0);
    res = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) res++;
      step();
    end
    chk("mid_no_stale", res, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
